issue_pipe_buf: RTL

Per-FU issue buffer between the reservation station and the functional units, generalising the single-entry elastic stage to FU_CNT channels of DEPTH entries each. Each channel keeps its uops in arrival order and drives the head uop's PRF read addresses. On a branch recovery it kills only uops younger than the mispredicting branch, compacting the survivors in order; a full flush kills everything. An optional bypass mode gives 0-cycle latency through an empty channel.

---
 rtl/issue_pipe_buf_pkg.sv | 32 +++
 rtl/issue_chan_buf.sv | 119 +++++++++++
 rtl/issue_pipe_buf.sv | 59 +++++
 3 files changed

// File: rtl/issue_pipe_buf_pkg.sv
// Shared types for the per-FU issue buffer: the issued uop format and the
// ROB age helper used to decide which uops a branch recovery kills.
package issue_pipe_buf_pkg;

  localparam int ROB_W  = 5;
  localparam int PHYS_W = 6;
  localparam int FU_NUM = 4;

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_BRU   = 2'd1,
    FU_STORE = 2'd2,
    FU_LOAD  = 2'd3
  } fu_type_e;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_idx;
    logic [PHYS_W-1:0] prs1;
    logic [PHYS_W-1:0] prs2;
    logic [PHYS_W-1:0] prd;
    logic [1:0]        br_epoch;
    logic [7:0]        opcode;
    fu_type_e          fu;
  } rs_uop_t;

  // Distance from the ROB head; larger means younger.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                               input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/issue_chan_buf.sv
// One issue channel: an in-order buffer of DEPTH uops with selective kill and
// in-order compaction, optional zero-latency bypass, and PRF read address drive.
module issue_chan_buf
  import issue_pipe_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter bit BYPASS = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_valid,
  input  logic              recover_valid,
  input  logic [ROB_W-1:0]  recover_rob_idx,
  input  logic [ROB_W-1:0]  rob_head_idx,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  rs_uop_t           issue_uop,
  output logic              fu_req_valid,
  input  logic              fu_req_ready,
  output rs_uop_t           fu_req_uop,
  output logic [PHYS_W-1:0] raddr1,
  output logic [PHYS_W-1:0] raddr2,
  output logic [CNT_W-1:0]  occupancy
);

  rs_uop_t          r_slot [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic [ROB_W-1:0] w_br_age;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_kill_sh;
  logic [DEPTH-1:0] w_valid_sh;
  rs_uop_t          w_shift [DEPTH];
  rs_uop_t          w_slot_next [DEPTH];
  logic [CNT_W-1:0] w_count_sh;
  logic [CNT_W-1:0] w_count_next;
  logic             w_push_kill;
  logic             w_empty;
  logic             w_bypass_path;
  logic             w_pop;
  logic             w_pop_slot;
  logic             w_push;
  logic             w_push_store;

  assign w_br_age      = rob_age(recover_rob_idx, rob_head_idx);
  assign w_push_kill   = recover_valid && (rob_age(issue_uop.rob_idx, rob_head_idx) > w_br_age);
  assign w_empty       = (r_count == '0);
  assign w_bypass_path = BYPASS && w_empty;

  // Slots as they look after an optional pop, with their kill flags carried along.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_kill[gi] = recover_valid &&
                          (rob_age(r_slot[gi].rob_idx, rob_head_idx) > w_br_age);
      if (gi < DEPTH - 1) begin : g_mid
        assign w_shift[gi]   = w_pop_slot ? r_slot[gi+1] : r_slot[gi];
        assign w_kill_sh[gi] = w_pop_slot ? w_kill[gi+1] : w_kill[gi];
      end else begin : g_last
        assign w_shift[gi]   = r_slot[gi];
        assign w_kill_sh[gi] = w_kill[gi];
      end
      assign w_valid_sh[gi] = (CNT_W'(gi) < w_count_sh) && !w_kill_sh[gi];
    end
  endgenerate

  always_comb begin
    fu_req_valid = 1'b0;
    if (flush_valid) begin
      fu_req_valid = 1'b0;
    end else if (w_empty) begin
      fu_req_valid = BYPASS && rst_n && issue_valid && !w_push_kill;
    end else begin
      fu_req_valid = !w_kill[0];
    end
  end

  assign fu_req_uop  = w_bypass_path ? issue_uop : r_slot[0];
  assign w_pop       = fu_req_valid && fu_req_ready;
  assign w_pop_slot  = w_pop && !w_empty;
  assign issue_ready = (r_count < CNT_W'(DEPTH)) || w_pop;
  assign w_push      = issue_valid && issue_ready && !flush_valid;
  // A bypassed uop that the FU takes right away is never stored.
  assign w_push_store = w_push && !w_push_kill && !(w_empty && w_pop);
  assign w_count_sh   = r_count - CNT_W'(w_pop_slot);

  always_comb begin
    int unsigned pos;
    pos         = 0;
    w_slot_next = r_slot;
    for (int j = 0; j < DEPTH; j++) begin
      if (w_valid_sh[j]) begin
        w_slot_next[pos] = w_shift[j];
        pos++;
      end
    end
    if (w_push_store && (pos < DEPTH)) begin
      w_slot_next[pos] = issue_uop;
    end
    w_count_next = flush_valid ? '0 : (CNT_W'(pos) + CNT_W'(w_push_store));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    r_slot <= w_slot_next;
  end

  assign raddr1    = fu_req_valid ? fu_req_uop.prs1 : '0;
  assign raddr2    = fu_req_valid ? fu_req_uop.prs2 : '0;
  assign occupancy = r_count;

endmodule

// File: rtl/issue_pipe_buf.sv
// Issue buffer between the reservation station and the functional units:
// one independent channel per FU, plus a global busy indication.
module issue_pipe_buf
  import issue_pipe_buf_pkg::*;
#(
  parameter int FU_CNT = FU_NUM,
  parameter int DEPTH  = 2,
  parameter bit BYPASS = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FU_CNT-1:0]              issue_valid,
  output logic [FU_CNT-1:0]              issue_ready,
  input  rs_uop_t [FU_CNT-1:0]           issue_uop,
  output logic [FU_CNT-1:0]              fu_req_valid,
  input  logic [FU_CNT-1:0]              fu_req_ready,
  output rs_uop_t [FU_CNT-1:0]           fu_req_uop,
  output logic [FU_CNT-1:0][PHYS_W-1:0]  raddr1,
  output logic [FU_CNT-1:0][PHYS_W-1:0]  raddr2,
  input  logic                           flush_valid,
  input  logic                           recover_valid,
  input  logic [ROB_W-1:0]               recover_rob_idx,
  input  logic [ROB_W-1:0]               rob_head_idx,
  output logic [FU_CNT-1:0][CNT_W-1:0]   occupancy,
  output logic                           busy
);

  logic [FU_CNT-1:0] w_nonempty;

  generate
    for (genvar gi = 0; gi < FU_CNT; gi++) begin : g_chan
      issue_chan_buf #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
      ) u_chan (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_valid     (flush_valid),
        .recover_valid   (recover_valid),
        .recover_rob_idx (recover_rob_idx),
        .rob_head_idx    (rob_head_idx),
        .issue_valid     (issue_valid[gi]),
        .issue_ready     (issue_ready[gi]),
        .issue_uop       (issue_uop[gi]),
        .fu_req_valid    (fu_req_valid[gi]),
        .fu_req_ready    (fu_req_ready[gi]),
        .fu_req_uop      (fu_req_uop[gi]),
        .raddr1          (raddr1[gi]),
        .raddr2          (raddr2[gi]),
        .occupancy       (occupancy[gi])
      );
      assign w_nonempty[gi] = |occupancy[gi];
    end
  endgenerate

  assign busy = |w_nonempty;

endmodule
